// File: rtl/aes_frame_loader.sv
`timescale 1ns/1ps
// Assembles a byte-serial AES frame (16/24/32-byte key + 16-byte block) into wide key/block words.
// Latency: out_valid rises 1 clk after the final byte is accepted; one frame per N+1 cycles unstalled.
// Backpressure: in_ready drops while a finished frame waits in HOLD for out_ready; gaps on in_valid stall assembly.
module aes_frame_loader #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic [1:0]   in_mode,
  input  logic         in_decrypt,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [255:0] out_key,
  output logic [127:0] out_block,
  output logic [1:0]   out_mode,
  output logic         out_decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_DATA,
    S_HOLD,
    S_DRAIN
  } state_t;

  // A TIMEOUT of 0 switches the idle-gap abort off entirely.
  localparam logic            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [255:0]    key_q, key_d;
  logic [127:0]    blk_q, blk_d;
  logic [1:0]      mode_q, mode_d;
  logic            dec_q, dec_d;
  logic            err_q, err_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic            acc;
  logic            to_hit;
  logic [5:0]      key_last;
  logic [5:0]      frame_last;
  logic [3:0]      blk_idx;
  logic [7:0]      key_sh;
  logic [6:0]      blk_sh;

  // Byte bookkeeping: handshake, frame boundaries and byte-lane shift amounts.
  always_comb begin
    acc    = in_valid && in_ready_q;
    // Fires on the idle cycle that would bring the gap count up to TIMEOUT.
    to_hit = TO_EN && !acc && (to_q == TO_LAST);
    case (mode_q)
      2'b00:   key_last = 6'd15;
      2'b01:   key_last = 6'd23;
      default: key_last = 6'd31;
    endcase
    frame_last = key_last + 6'd16;
    // Block byte index is cnt - K; K is 16/24/32 so only the 24-byte key shifts the low nibble.
    blk_idx    = cnt_q[3:0] - ((mode_q == 2'b01) ? 4'd8 : 4'd0);
    // Byte i lands at bit offset 8*(last_byte - i); ~i gives last_byte - i within the lane count.
    key_sh     = {~cnt_q[4:0], 3'b000};
    blk_sh     = {~blk_idx, 3'b000};
  end

  // Next-state and datapath updates for the frame FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = '0;
    key_d   = key_q;
    blk_d   = blk_q;
    mode_d  = mode_q;
    dec_d   = dec_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (in_mode == 2'b11) begin
            err_d   = 1'b1;
            state_d = in_last ? S_IDLE : S_DRAIN;
          end else begin
            mode_d = in_mode;
            dec_d  = in_decrypt;
            key_d  = {in_data, 248'd0};
            cnt_d  = 6'd1;
            if (in_last) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_KEY;
            end
          end
        end
      end
      S_KEY, S_DATA: begin
        if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (acc) begin
          cnt_d = cnt_q + 6'd1;
          if (state_q == S_KEY) begin
            key_d = (key_q & ~(256'hFF << key_sh)) | (256'(in_data) << key_sh);
          end else begin
            blk_d = (blk_q & ~(128'hFF << blk_sh)) | (128'(in_data) << blk_sh);
          end
          if (cnt_q == frame_last) begin
            // Full length reached: a missing in_last means the frame overruns, so discard the tail.
            err_d   = !in_last;
            state_d = in_last ? S_HOLD : S_DRAIN;
          end else if (in_last) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (cnt_q == key_last) begin
            state_d = S_DATA;
          end
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (to_hit) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (acc) begin
          if (in_last) state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d != S_HOLD);
    out_valid_d = (state_d == S_HOLD);
  end

  // State and registered outputs; reset drops any frame in flight without flagging an error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      to_q        <= '0;
      key_q       <= '0;
      blk_q       <= '0;
      mode_q      <= 2'b00;
      dec_q       <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      key_q       <= key_d;
      blk_q       <= blk_d;
      mode_q      <= mode_d;
      dec_q       <= dec_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_key     = key_q;
  assign out_block   = blk_q;
  assign out_mode    = mode_q;
  assign out_decrypt = dec_q;
  assign err         = err_q;

endmodule

// File: tb/tb_aes_frame_loader.sv
`timescale 1ns/1ps
// Bench for aes_frame_loader: scoreboarded frames, error paths, timeout and reset recovery.
// A second instance with a short timeout shares the inputs and is only observed in the timeout test.
// Inputs change #1 after the rising edge or in the low phase; outputs are sampled on the falling edge.
module tb_aes_frame_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic [7:0]   in_data = '0;
  logic [1:0]   in_mode = '0;
  logic         in_decrypt = 1'b0, in_last = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid, out_decrypt, err;
  logic [255:0] out_key;
  logic [127:0] out_block;
  logic [1:0]   out_mode;
  logic         to_in_ready, to_out_valid, to_out_decrypt, to_err;
  logic [255:0] to_out_key;
  logic [127:0] to_out_block;
  logic [1:0]   to_out_mode;

  aes_frame_loader #(.TIMEOUT(1023), .TO_W(10)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_mode(in_mode), .in_decrypt(in_decrypt),
    .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready), .out_key(out_key),
    .out_block(out_block), .out_mode(out_mode), .out_decrypt(out_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .err(err));

  aes_frame_loader #(.TIMEOUT(8), .TO_W(10)) dut_to (
    .clk(clk), .reset(reset), .in_data(in_data), .in_mode(in_mode), .in_decrypt(in_decrypt),
    .in_last(in_last), .in_valid(in_valid), .in_ready(to_in_ready), .out_key(to_out_key),
    .out_block(to_out_block), .out_mode(to_out_mode), .out_decrypt(to_out_decrypt),
    .out_valid(to_out_valid), .out_ready(out_ready), .err(to_err));

  typedef struct {
    logic [255:0] key;
    logic [127:0] blk;
    logic [1:0]   mode;
    logic         dec;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  int err_cnt = 0, to_err_cnt = 0;

  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (to_err === 1'b1) to_err_cnt++;
  end

  function automatic logic [255:0] mk_key(input int n);
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < 32; i++) k = {k[247:0], (i < n) ? 8'(i) : 8'h00};
    return k;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic [1:0] m, input logic dc,
                           input logic last, input int gap, output time t_acc);
    int w;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_data = d; in_mode = m; in_decrypt = dc; in_last = last; in_valid = 1'b1;
    w = 0;
    if (clk) @(negedge clk);
    while (in_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      total++; bad++;
      $display("FAIL in_ready_wait got=%b exp=1", in_ready);
    end
    @(posedge clk);
    t_acc = $time;
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] m, input logic dc, input logic [255:0] key,
                            input logic [127:0] blk, input int maxgap,
                            output time t_first, output time t_last);
    int k;
    logic [255:0] ks;
    logic [127:0] bs;
    logic [7:0] b;
    exp_t e;
    time t;
    k = (m == 2'b00) ? 16 : (m == 2'b01) ? 24 : 32;
    e.key = key; e.blk = blk; e.mode = m; e.dec = dc;
    sb.push_back(e);
    ks = key; bs = blk;
    t_first = 0; t_last = 0;
    for (int i = 0; i < k + 16; i++) begin
      if (i < k) begin b = ks[255:248]; ks = ks << 8; end
      else begin b = bs[127:120]; bs = bs << 8; end
      send_byte(b, m, dc, (i == k + 15), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0, t);
      if (i == 0) t_first = t;
      t_last = t;
    end
  endtask

  task automatic capture(output exp_t o, output int waited);
    waited = 1;
    @(negedge clk);
    while (out_valid !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    o.key = out_key; o.blk = out_block; o.mode = out_mode; o.dec = out_decrypt;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    total++; if (out_key !== 256'd0) begin bad++; $display("FAIL rst_key got=%h exp=0", out_key); end
    total++; if (out_block !== 128'd0) begin bad++; $display("FAIL rst_block got=%h exp=0", out_block); end
    total++; if (out_mode !== 2'b00) begin bad++; $display("FAIL rst_mode got=%b exp=00", out_mode); end
    total++; if (out_decrypt !== 1'b0) begin bad++; $display("FAIL rst_dec got=%b exp=0", out_decrypt); end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_mode128();
    exp_t o, e;
    int w, e0;
    time tf, tl;
    e0 = err_cnt;
    out_ready = 1'b1;
    send_frame(2'b00, 1'b0, mk_key(16), 128'h00112233445566778899aabbccddeeff, 0, tf, tl);
    capture(o, w);
    e = sb.pop_front();
    total++; if (w !== 1) begin bad++; $display("FAIL m128_latency got=%0d exp=1", w); end
    total++; if (o.key !== e.key) begin bad++; $display("FAIL m128_key got=%h exp=%h", o.key, e.key); end
    total++; if (o.blk !== e.blk) begin bad++; $display("FAIL m128_block got=%h exp=%h", o.blk, e.blk); end
    total++; if (o.mode !== e.mode) begin bad++; $display("FAIL m128_mode got=%b exp=%b", o.mode, e.mode); end
    total++; if (o.dec !== e.dec) begin bad++; $display("FAIL m128_dec got=%b exp=%b", o.dec, e.dec); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL m128_valid_1cyc got=%b exp=0", out_valid); end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL m128_no_err got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_mode192_backpressure();
    exp_t o, e;
    int w, unstable;
    time tf, tl;
    out_ready = 1'b0;
    send_frame(2'b01, 1'b1, mk_key(24), 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 0, tf, tl);
    capture(o, w);
    e = sb.pop_front();
    total++; if (w !== 1) begin bad++; $display("FAIL m192_latency got=%0d exp=1", w); end
    total++; if (o.key !== e.key) begin bad++; $display("FAIL m192_key got=%h exp=%h", o.key, e.key); end
    total++; if (o.blk !== e.blk) begin bad++; $display("FAIL m192_block got=%h exp=%h", o.blk, e.blk); end
    total++; if (o.mode !== e.mode) begin bad++; $display("FAIL m192_mode got=%b exp=%b", o.mode, e.mode); end
    total++; if (o.dec !== 1'b1) begin bad++; $display("FAIL m192_dec got=%b exp=1", o.dec); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL m192_hold_ready got=%b exp=0", in_ready); end
    unstable = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_key !== e.key || out_block !== e.blk ||
          out_mode !== e.mode || out_decrypt !== e.dec) unstable++;
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL m192_stable got=%0d exp=0", unstable); end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL m192_release_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL m192_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_mode256_gaps();
    exp_t o, e;
    int w, e0;
    time tf, tl;
    e0 = err_cnt;
    out_ready = 1'b1;
    send_frame(2'b10, 1'b0, mk_key(32), 128'h8ea2b7ca516745bfeafc49904b496089, 20, tf, tl);
    capture(o, w);
    e = sb.pop_front();
    total++; if (w !== 1) begin bad++; $display("FAIL m256_latency got=%0d exp=1", w); end
    total++; if (o.key !== e.key) begin bad++; $display("FAIL m256_key got=%h exp=%h", o.key, e.key); end
    total++; if (o.blk !== e.blk) begin bad++; $display("FAIL m256_block got=%h exp=%h", o.blk, e.blk); end
    total++; if (o.mode !== 2'b10) begin bad++; $display("FAIL m256_mode got=%b exp=10", o.mode); end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL m256_no_err got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_early_last();
    int e0, ov;
    time t;
    e0 = err_cnt;
    for (int i = 0; i < 20; i++) send_byte(8'(i), 2'b00, 1'b0, (i == 19), 0, t);
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL early_err got=%b exp=1", err); end
    ov = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b0) ov++;
    end
    total++; if (ov !== 0) begin bad++; $display("FAIL early_no_valid got=%0d exp=0", ov); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL early_ready got=%b exp=1", in_ready); end
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL early_err_once got=%0d exp=1", err_cnt - e0); end
  endtask

  task automatic test_bad_mode();
    exp_t o, e;
    int w, e0;
    time t, tf, tl;
    e0 = err_cnt;
    send_byte(8'hA5, 2'b11, 1'b0, 1'b0, 0, t);
    @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL badmode_err got=%b exp=1", err); end
    for (int i = 1; i < 5; i++) send_byte(8'(8'hB0 + i), 2'b11, 1'b0, (i == 4), 0, t);
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL badmode_no_valid got=%b exp=0", out_valid); end
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL badmode_err_once got=%0d exp=1", err_cnt - e0); end
    send_frame(2'b00, 1'b0, mk_key(16), 128'hffeeddccbbaa99887766554433221100, 0, tf, tl);
    capture(o, w);
    e = sb.pop_front();
    total++; if (w !== 1) begin bad++; $display("FAIL badmode_next_latency got=%0d exp=1", w); end
    total++; if (o.key !== e.key) begin bad++; $display("FAIL badmode_next_key got=%h exp=%h", o.key, e.key); end
    total++; if (o.blk !== e.blk) begin bad++; $display("FAIL badmode_next_block got=%h exp=%h", o.blk, e.blk); end
  endtask

  task automatic test_back_to_back();
    exp_t o, e;
    int w;
    time ta_f, ta_l, tb_f, tb_l;
    out_ready = 1'b1;
    fork
      begin
        send_frame(2'b00, 1'b0, mk_key(16), 128'h0f0e0d0c0b0a09080706050403020100, 0, ta_f, ta_l);
        send_frame(2'b01, 1'b1, mk_key(24), 128'h55aa55aa00ff00ff1234567890abcdef, 0, tb_f, tb_l);
      end
      begin
        exp_t oa, ea;
        int wa;
        capture(oa, wa);
        ea = sb.pop_front();
        total++; if (oa.key !== ea.key) begin bad++; $display("FAIL b2b_a_key got=%h exp=%h", oa.key, ea.key); end
        total++; if (oa.blk !== ea.blk) begin bad++; $display("FAIL b2b_a_block got=%h exp=%h", oa.blk, ea.blk); end
      end
    join
    total++; if (tb_f - ta_l !== 20) begin bad++; $display("FAIL b2b_gap got=%0t exp=20", tb_f - ta_l); end
    capture(o, w);
    e = sb.pop_front();
    total++; if (w !== 1) begin bad++; $display("FAIL b2b_b_latency got=%0d exp=1", w); end
    total++; if (o.key !== e.key) begin bad++; $display("FAIL b2b_b_key got=%h exp=%h", o.key, e.key); end
    total++; if (o.blk !== e.blk) begin bad++; $display("FAIL b2b_b_block got=%h exp=%h", o.blk, e.blk); end
    total++; if (o.dec !== e.dec) begin bad++; $display("FAIL b2b_b_dec got=%b exp=%b", o.dec, e.dec); end
  endtask

  task automatic test_timeout();
    int k, t0, e0, rdy_bad;
    logic found;
    time t;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    t0 = to_err_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 10; i++) send_byte(8'(i), 2'b00, 1'b0, 1'b0, 0, t);
    k = 0;
    found = 1'b0;
    while (k < 30 && !found) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (to_err === 1'b1) found = 1'b1;
    end
    total++; if (k !== 8) begin bad++; $display("FAIL timeout_delay got=%0d exp=8", k); end
    rdy_bad = (to_in_ready !== 1'b1) ? 1 : 0;
    @(negedge clk);
    total++; if (to_err !== 1'b0) begin bad++; $display("FAIL timeout_pulse_width got=%b exp=0", to_err); end
    repeat (10) begin
      @(negedge clk);
      if (to_in_ready !== 1'b1) rdy_bad++;
    end
    total++; if (rdy_bad !== 0) begin bad++; $display("FAIL timeout_ready got=%0d exp=0", rdy_bad); end
    total++; if (to_err_cnt - t0 !== 1) begin bad++; $display("FAIL timeout_once got=%0d exp=1", to_err_cnt - t0); end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL timeout_long_quiet got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_reset_midframe();
    exp_t o, e;
    int w, e0;
    time t, tf, tl;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    e0 = err_cnt;
    for (int i = 0; i < 26; i++) send_byte(8'(8'h80 + i), 2'b00, 1'b1, 1'b0, 0, t);
    reset = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
    total++; if (out_key !== 256'd0) begin bad++; $display("FAIL midrst_key got=%h exp=0", out_key); end
    total++; if (out_block !== 128'd0) begin bad++; $display("FAIL midrst_block got=%h exp=0", out_block); end
    total++; if (out_decrypt !== 1'b0) begin bad++; $display("FAIL midrst_dec got=%b exp=0", out_decrypt); end
    total++; if (out_mode !== 2'b00) begin bad++; $display("FAIL midrst_mode got=%b exp=00", out_mode); end
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL midrst_no_err got=%0d exp=0", err_cnt - e0); end
    send_frame(2'b00, 1'b0, mk_key(16), 128'h00112233445566778899aabbccddeeff, 0, tf, tl);
    capture(o, w);
    e = sb.pop_front();
    total++; if (w !== 1) begin bad++; $display("FAIL midrst_next_latency got=%0d exp=1", w); end
    total++; if (o.key !== e.key) begin bad++; $display("FAIL midrst_next_key got=%h exp=%h", o.key, e.key); end
    total++; if (o.blk !== e.blk) begin bad++; $display("FAIL midrst_next_block got=%h exp=%h", o.blk, e.blk); end
    total++; if (o.dec !== 1'b0) begin bad++; $display("FAIL midrst_next_dec got=%b exp=0", o.dec); end
  endtask

  initial begin
    test_reset();
    test_mode128();
    test_mode192_backpressure();
    test_mode256_gaps();
    test_early_last();
    test_bad_mode();
    test_back_to_back();
    test_timeout();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
